iir_out_stage: RTL and testbench



---
 rtl/iir_pkg.sv | 43 ++++
 rtl/iir_out_fifo.sv | 63 ++++++
 rtl/iir_out_stage.sv | 101 ++++++++++
 tb/tb_iir_out_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Fixed-point formats shared with the SOS cascade, plus reusable round/saturate helpers.
// Helpers use 64-bit signed arithmetic; callers truncate to their own widths.
package iir_pkg;

  localparam int NDINT  = 3;
  localparam int NDFRAC = 22;
  localparam int NOINT  = 1;
  localparam int NOFRAC = 15;

  typedef logic signed [NDINT+NDFRAC-1:0] sample_t;

  function automatic logic signed [63:0] sat_hi(input int unsigned ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int unsigned ow);
    return -(64'sd1 <<< (ow - 1));
  endfunction

  // Round half up: add half an output LSB, then arithmetic shift drops the fraction.
  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] x,
                                                       input int unsigned drop);
    return (x + (64'sd1 <<< (drop - 1))) >>> drop;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int unsigned ow);
    if (x > sat_hi(ow)) return sat_hi(ow);
    if (x < sat_lo(ow)) return sat_lo(ow);
    return x;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] x, input int unsigned ow);
    return (x > sat_hi(ow)) || (x < sat_lo(ow));
  endfunction

  function automatic logic signed [63:0] round_sat(input logic signed [63:0] x,
                                                   input int unsigned drop = NDFRAC - NOFRAC,
                                                   input int unsigned ow = NOINT + NOFRAC);
    return saturate(round_half_up(x, drop), ow);
  endfunction

endpackage

// File: rtl/iir_out_fifo.sv
// Synchronous FIFO with a registered head; the head register is one of the DEPTH slots.
// A full FIFO accepts a write in the same cycle its head is popped.
module iir_out_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_drop
);
  import iir_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("iir_out_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr, r_rd_ptr;
  logic         r_valid;
  logic [W-1:0] r_data;

  logic         w_full, w_pop, w_push, w_valid_n;
  logic [AW:0]  w_wr_ptr_n, w_rd_ptr_n;

  assign w_full     = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}};
  assign w_pop      = r_valid && i_ready;
  assign w_push     = i_wr && (!w_full || w_pop);
  assign o_drop     = i_wr && w_full && !w_pop;
  assign w_wr_ptr_n = r_wr_ptr + (AW+1)'(w_push);
  assign w_rd_ptr_n = r_rd_ptr + (AW+1)'(w_pop);
  assign w_valid_n  = w_wr_ptr_n != w_rd_ptr_n;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  // Head mirrors mem[rd_ptr]; if the new head is the slot written this edge, take the write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_n;
      r_rd_ptr <= w_rd_ptr_n;
      r_valid  <= w_valid_n;
      if ((w_pop || !r_valid) && w_valid_n)
        r_data <= (w_rd_ptr_n == r_wr_ptr) ? i_wdata : r_mem[w_rd_ptr_n[AW-1:0]];
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/iir_out_stage.sv
// Output stage: capture, round, saturate, then buffer for a valid/ready consumer.
// Define IIR_OUT_SATCNT_EN to build the saturation event counter; otherwise sat_count is 0.
module iir_out_stage #(
  parameter int NDINT      = iir_pkg::NDINT,
  parameter int NDFRAC     = iir_pkg::NDFRAC,
  parameter int NOINT      = iir_pkg::NOINT,
  parameter int NOFRAC     = iir_pkg::NOFRAC,
  parameter int FIFO_DEPTH = 8,
  parameter int SATCNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dv_in,
  input  logic signed [NDINT+NDFRAC-1:0] d_in,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NOINT+NOFRAC-1:0]       m_data,
  output logic                          overflow,
  output logic [SATCNT_W-1:0]           sat_count,
  input  logic                          clr_status
);
  import iir_pkg::*;

  localparam int IW   = NDINT + NDFRAC;
  localparam int OW   = NOINT + NOFRAC;
  localparam int NR   = NDINT + NOFRAC + 1;
  localparam int DROP = NDFRAC - NOFRAC;

  if (!(NDFRAC > NOFRAC && NDINT >= NOINT)) begin : g_bad_fmt
    $error("iir_out_stage: need NDFRAC > NOFRAC and NDINT >= NOINT");
  end

  logic                 r_in_vld, r_s1_vld, r_s2_vld;
  logic signed [IW-1:0] r_in;
  logic signed [NR-1:0] r_s1;
  logic [OW-1:0]        r_s2;
  logic                 r_ovf;
  logic                 w_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_vld <= 1'b0;
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_in     <= '0;
      r_s1     <= '0;
      r_s2     <= '0;
    end else begin
      r_in_vld <= dv_in;
      r_in     <= d_in;
      r_s1_vld <= r_in_vld;
      r_s1     <= NR'(round_half_up(64'(r_in), DROP));
      r_s2_vld <= r_s1_vld;
      r_s2     <= OW'(saturate(64'(r_s1), OW));
    end
  end

  iir_out_fifo #(
    .W     (OW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (r_s2_vld),
    .i_wdata (r_s2),
    .o_valid (m_valid),
    .i_ready (m_ready),
    .o_data  (m_data),
    .o_drop  (w_drop)
  );

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)             r_ovf <= 1'b0;
    else if (w_drop)     r_ovf <= 1'b1;
    else if (clr_status) r_ovf <= 1'b0;
  end

  assign overflow = r_ovf;

`ifdef IIR_OUT_SATCNT_EN
  logic                r_s2_sat;
  logic [SATCNT_W-1:0] r_sat_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_s2_sat <= 1'b0;
    else     r_s2_sat <= r_s1_vld && sat_hit(64'(r_s1), OW);
  end

  always_ff @(posedge clk) begin
    if (rst)                              r_sat_cnt <= '0;
    else if (clr_status)                  r_sat_cnt <= SATCNT_W'(r_s2_sat);
    else if (r_s2_sat && r_sat_cnt != '1) r_sat_cnt <= r_sat_cnt + SATCNT_W'(1);
  end

  assign sat_count = r_sat_cnt;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_iir_out_stage.sv
// Randomized and directed checks of iir_out_stage against a queue-based reference model.
module tb_iir_out_stage;
  import iir_pkg::*;

  localparam int DEPTH = 8;
`ifdef IIR_OUT_SATCNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv_in = 1'b0;
  sample_t     d_in = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        overflow;
  logic [15:0] sat_count;
  logic        clr_status = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int          mq[$];
  logic [15:0] obs[$];
  logic        pv[3];
  int          pd[3];
  logic        ovf_m = 1'b0;
  int          cnt_m = 0;

  always #5 clk = ~clk;

  iir_out_stage #(
    .NDINT      (3),
    .NDFRAC     (22),
    .NOINT      (1),
    .NOFRAC     (15),
    .FIFO_DEPTH (DEPTH),
    .SATCNT_W   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dv_in      (dv_in),
    .d_in       (d_in),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .overflow   (overflow),
    .sat_count  (sat_count),
    .clr_status (clr_status)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Q3.22 -> Q1.15: floor((raw + 64) / 128), then clamp to 16-bit signed.
  function automatic void ref_out(input int raw, output int q, output logic sat);
    int s, fl;
    s = raw + 64;
    if (s >= 0) fl = s / 128;
    else        fl = -((-s + 127) / 128);
    q = fl;
    sat = 1'b0;
    if (fl > 32767) begin
      q = 32767;
      sat = 1'b1;
    end else if (fl < -32768) begin
      q = -32768;
      sat = 1'b1;
    end
  endfunction

  task automatic cycle(input logic dv, input int raw, input logic rdy, input logic clr,
                       input logic rs);
    logic        cv, sat, pop, drop;
    int          cd, q;
    logic [15:0] e16;
    dv_in = dv; d_in = sample_t'(raw); m_ready = rdy; clr_status = clr; rst = rs;
    @(negedge clk);
    if (m_valid && m_ready) obs.push_back(m_data);
    @(posedge clk);
    if (rs) begin
      mq.delete();
      for (int i = 0; i < 3; i++) begin
        pv[i] = 1'b0;
        pd[i] = 0;
      end
      ovf_m = 1'b0;
      cnt_m = 0;
    end else begin
      pop = (mq.size() > 0) && rdy;
      cv = pv[2]; cd = pd[2];
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = dv;    pd[0] = raw;
      if (pop) void'(mq.pop_front());
      drop = 1'b0; sat = 1'b0;
      if (cv) begin
        ref_out(cd, q, sat);
        if (mq.size() >= DEPTH) drop = 1'b1;
        else mq.push_back(q);
      end
      if (drop)     ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
      if (SAT_EN) begin
        if (clr)                       cnt_m = sat ? 1 : 0;
        else if (sat && cnt_m < 65535) cnt_m++;
      end
    end
    #1;
    check("valid", 32'(m_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      e16 = 16'(mq[0]);
      check("data", {16'h0, m_data}, {16'h0, e16});
    end
    check("ovf", 32'(overflow), 32'(ovf_m));
    check("satcnt", {16'h0, sat_count}, 32'(cnt_m));
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, rdy, 1'b0, 1'b0);
  endtask

  task automatic send_and_expect(input string tag, input int raw, input logic [15:0] exp);
    int          lat;
    logic        seen;
    logic [15:0] got;
    got = '0; seen = 1'b0; lat = 0;
    cycle(1'b1, raw, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12 && !seen; i++) begin
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      lat++;
      if (m_valid) begin
        seen = 1'b1;
        got = m_data;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_val"}, {16'h0, got}, {16'h0, exp});
    idle(2, 1'b1);
  endtask

  initial begin
    int raw;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pd[i] = 0;
    end

    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", {16'h0, m_data}, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_satcnt", {16'h0, sat_count}, 32'd0);
    idle(2, 1'b1);

    send_and_expect("basic", 32'h0020_0000, 16'h4000);
    send_and_expect("rnd_p64", 64, 16'h0001);
    send_and_expect("rnd_p63", 63, 16'h0000);
    send_and_expect("rnd_m64", -64, 16'h0000);
    send_and_expect("rnd_m65", -65, 16'hFFFF);

    send_and_expect("sat_pos", 2 * 4194304, 16'h7FFF);
    check("sat_cnt1", {16'h0, sat_count}, SAT_EN ? 32'd1 : 32'd0);
    send_and_expect("sat_neg", -3 * 4194304, 16'h8000);
    check("sat_cnt2", {16'h0, sat_count}, SAT_EN ? 32'd2 : 32'd0);
    cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
    check("sat_clr", {16'h0, sat_count}, 32'd0);

    for (int k = 1; k <= 10; k++) cycle(1'b1, k * 128, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("bp_ovf_set", 32'(overflow), 32'd1);
    obs.delete();
    idle(12, 1'b1);
    check("bp_count", 32'(obs.size()), 32'd8);
    for (int i = 0; i < obs.size(); i++) check("bp_order", {16'h0, obs[i]}, 32'(i + 1));
    check("bp_ovf_hold", 32'(overflow), 32'd1);
    cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
    check("bp_ovf_clr", 32'(overflow), 32'd0);

    for (int k = 1; k <= 8; k++) cycle(1'b1, k * 128, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    obs.delete();
    for (int k = 1; k <= 20; k++) cycle(1'b1, (100 + k) * 128, 1'b1, 1'b0, 1'b0);
    idle(15, 1'b1);
    check("st_ovf", 32'(overflow), 32'd0);
    check("st_count", 32'(obs.size()), 32'd28);
    for (int i = 0; i < obs.size(); i++)
      check("st_order", {16'h0, obs[i]}, (i < 8) ? 32'(i + 1) : 32'(101 + i - 8));

    for (int k = 1; k <= 4; k++) cycle(1'b1, k * 128, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    cycle(1'b1, 50 * 128, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 51 * 128, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    obs.delete();
    idle(6, 1'b1);
    check("mid_rst_stale", 32'(obs.size()), 32'd0);
    send_and_expect("post_rst", 5 * 128, 16'd5);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) != 0) raw = int'($urandom_range(0, 33554431)) - 16777216;
      else                           raw = int'($urandom_range(0, 8191)) - 4096;
      cycle(($urandom_range(0, 3) != 0), raw, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0));
    end
    idle(15, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
